// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, widths and helpers for the seven-segment scan controller
// Exports: SEG_OFF, MAX_DIGITS, IDX_W, digit_idx_t, cnt_width(), msd_idx()
package seven_seg_pkg;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W = $clog2(MAX_DIGITS);
    localparam logic [6:0] SEG_OFF = 7'h7F;
    typedef logic [IDX_W-1:0] digit_idx_t;
    function automatic int cnt_width(input int period);
        return $clog2(period) < 1 ? 1 : $clog2(period);
    endfunction
    // index of the highest nonzero nibble, 0 when the whole value is zero
    function automatic digit_idx_t msd_idx(input logic [4*MAX_DIGITS-1:0] v);
        digit_idx_t m;
        m = '0;
        for (int i = 1; i < MAX_DIGITS; i++)
            if (v[4*i +: 4] != 4'h0) m = digit_idx_t'(i);
        return m;
    endfunction
endpackage

// File: rtl/bto7s.sv
// bto7s: hex nibble to seven-segment decoder, active-high segments
// Ports: x_in nibble in; s_out segments {g,f,e,d,c,b,a}, 1 = segment on
module bto7s (
    input  logic [3:0] x_in,
    output logic [6:0] s_out
);
    always_comb begin
        case (x_in)
            4'h0: s_out = 7'h3F;
            4'h1: s_out = 7'h06;
            4'h2: s_out = 7'h5B;
            4'h3: s_out = 7'h4F;
            4'h4: s_out = 7'h66;
            4'h5: s_out = 7'h6D;
            4'h6: s_out = 7'h7D;
            4'h7: s_out = 7'h07;
            4'h8: s_out = 7'h7F;
            4'h9: s_out = 7'h6F;
            4'hA: s_out = 7'h77;
            4'hB: s_out = 7'h7C;
            4'hC: s_out = 7'h39;
            4'hD: s_out = 7'h5E;
            4'hE: s_out = 7'h79;
            default: s_out = 7'h71;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed common-anode display scanner with frame-aligned value commit
// Ports: clk_in/rst_n_in clock and async active-low reset; en_in scan enable;
//        val_in/val_valid_in value and capture strobe; dp_in live decimal points;
//        lz_en_in leading-zero suppression; commit_out commit pulse;
//        cat_out/dp_out/an_out active-low segments, decimal point and anodes
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    en_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    val_valid_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en_in,
    output logic                    commit_out,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);
    localparam int CW = cnt_width(COUNT_PERIOD);
    localparam int VW = 4*NUM_DIGITS;

    logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
    digit_idx_t            digit_idx_q, digit_idx_d;
    logic [VW-1:0]         disp_reg_q, disp_reg_d, pend_reg_q, pend_reg_d;
    logic                  pend_flag_q, pend_flag_d, commit_q, commit_d;
    logic [6:0]            cat_q, cat_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  slot_end, frame_end, commit, lit;
    logic [4*MAX_DIGITS-1:0] disp_w;
    logic [MAX_DIGITS-1:0] dp_w;
    logic [3:0]            nib;
    logic [6:0]            seg;

    // widen to the package maximum so digit_idx_t indexes without range issues
    assign disp_w = (4*MAX_DIGITS)'(disp_reg_q);
    assign dp_w   = MAX_DIGITS'(dp_in);
    assign nib    = disp_w[{digit_idx_q, 2'b00} +: 4];

    bto7s u_dec (
        .x_in  (nib),
        .s_out (seg)
    );

    always_comb begin
        slot_end    = slot_cnt_q == CW'(COUNT_PERIOD-1);
        frame_end   = en_in && slot_end && digit_idx_q == digit_idx_t'(NUM_DIGITS-1);
        slot_cnt_d  = !en_in ? slot_cnt_q : slot_end ? '0 : slot_cnt_q + CW'(1);
        digit_idx_d = !(en_in && slot_end) ? digit_idx_q : frame_end ? '0 : digit_idx_q + digit_idx_t'(1);
        // a strobe landing on the boundary commits straight through
        commit      = frame_end && (pend_flag_q || val_valid_in);
        pend_reg_d  = val_valid_in ? val_in : pend_reg_q;
        pend_flag_d = !commit && (pend_flag_q || val_valid_in);
        disp_reg_d  = !commit ? disp_reg_q : val_valid_in ? val_in : pend_reg_q;
        commit_d    = commit;
        lit         = en_in && slot_cnt_q >= CW'(BLANK_CYCLES)
                      && !(lz_en_in && digit_idx_q > msd_idx(disp_w));
        cat_d       = ~seg;
        dp_d        = ~dp_w[digit_idx_q];
        an_d        = lit ? ~(NUM_DIGITS'(1) << digit_idx_q) : '1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
            disp_reg_q  <= '0;
            pend_reg_q  <= '0;
            pend_flag_q <= 1'b0;
            commit_q    <= 1'b0;
            cat_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            disp_reg_q  <= disp_reg_d;
            pend_reg_q  <= pend_reg_d;
            pend_flag_q <= pend_flag_d;
            commit_q    <= commit_d;
            cat_q       <= cat_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign commit_out = commit_q;
    assign cat_out    = cat_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: randomized self-checking bench against a frame-position reference model
module tb_seven_seg_scan_ctrl;
    localparam int N = 8, CP = 4, BL = 1;

    logic        clk_in = 0, rst_n_in = 0, en_in = 0, val_valid_in = 0, lz_en_in = 0;
    logic [31:0] val_in = 0;
    logic [7:0]  dp_in = 0;
    logic        commit_out, dp_out;
    logic [6:0]  cat_out;
    logic [7:0]  an_out;

    int          checks = 0, errors = 0;
    int          p;
    logic [31:0] m_disp, m_pend;
    logic        m_flag;
    logic [7:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp, e_commit;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .COUNT_PERIOD(CP), .BLANK_CYCLES(BL)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .en_in        (en_in),
        .val_in       (val_in),
        .val_valid_in (val_valid_in),
        .dp_in        (dp_in),
        .lz_en_in     (lz_en_in),
        .commit_out   (commit_out),
        .cat_out      (cat_out),
        .dp_out       (dp_out),
        .an_out       (an_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg7(input logic [3:0] x);
        case (x)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int msd(input logic [31:0] v);
        int m = 0;
        for (int k = 1; k < N; k++) if ((v >> (4*k)) != 0) m = k;
        return m;
    endfunction

    // model position p counts enabled cycles; slot and digit fall out arithmetically
    function automatic logic at_boundary();
        return en_in && (p % CP) == CP-1 && ((p / CP) % N) == N-1;
    endfunction

    task automatic model_reset();
        p = 0; m_disp = 0; m_pend = 0; m_flag = 0;
    endtask

    task automatic tick();
        int slot, dig;
        logic cm;
        slot = p % CP;
        dig = (p / CP) % N;
        e_cat = ~seg7(4'(m_disp >> (4*dig)));
        e_dp = ~dp_in[dig];
        e_an = (en_in && slot >= BL && !(lz_en_in && dig > msd(m_disp))) ? ~(8'd1 << dig) : 8'hFF;
        cm = at_boundary() && (m_flag || val_valid_in);
        e_commit = cm;
        if (cm) begin
            m_disp = val_valid_in ? val_in : m_pend;
            m_flag = 0;
        end else if (val_valid_in) begin
            m_pend = val_in;
            m_flag = 1;
        end
        if (en_in) p++;
        @(posedge clk_in); #1;
        val_valid_in = 0;
    endtask

    task automatic test_reset();
        rst_n_in = 0; en_in = 1; lz_en_in = 0;
        #22;
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", an_out); end
        checks++; if (cat_out !== 7'h7F) begin errors++; $display("FAIL reset_cat got %h exp 7f", cat_out); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp_out); end
        checks++; if (commit_out !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit_out); end
        rst_n_in = 1;
        model_reset();
    endtask

    task automatic test_scan();
        int lowcnt[N];
        for (int d = 0; d < N; d++) lowcnt[d] = 0;
        for (int i = 0; i < 2*N*CP; i++) begin
            dp_in = 8'($urandom);
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL scan got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
            checks++; if (cat_out !== 7'h40) begin errors++; $display("FAIL scan_zero got %h exp 40", cat_out); end
            if (an_out != 8'hFF) lowcnt[(i / CP) % N]++;
        end
        for (int d = 0; d < N; d++) begin
            checks++; if (lowcnt[d] !== 2*(CP-BL)) begin errors++; $display("FAIL scan_lowcnt d%0d got %0d exp %0d", d, lowcnt[d], 2*(CP-BL)); end
        end
    endtask

    task automatic test_commit();
        int commits = 0;
        logic seen = 0;
        repeat (5) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL commit_pre got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
        end
        val_in = 32'h1234_ABCD; val_valid_in = 1;
        for (int i = 0; i < 2*N*CP && !seen; i++) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL commit_wait got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
            if (commit_out) begin commits++; seen = 1; end
        end
        if (!seen) begin errors++; $display("FAIL commit_timeout got none exp pulse"); end
        tick();
        checks++; if (cat_out !== 7'h21) begin errors++; $display("FAIL commit_digit0 got %h exp 21", cat_out); end
        if (commit_out) commits++;
        repeat (7*CP) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL commit_post got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
            if (commit_out) commits++;
        end
        checks++; if (cat_out !== 7'h79) begin errors++; $display("FAIL commit_digit7 got %h exp 79", cat_out); end
        checks++; if (commits !== 1) begin errors++; $display("FAIL commit_count got %0d exp 1", commits); end
    endtask

    task automatic test_last_wins();
        int commits = 0;
        logic seen = 0;
        for (int i = 0; i < N*CP && !at_boundary(); i++) tick();
        tick();
        val_in = 32'h11; val_valid_in = 1; tick();
        tick();
        val_in = 32'h22; val_valid_in = 1;
        for (int i = 0; i < 2*N*CP && !seen; i++) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL lastwins got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
            if (commit_out) begin commits++; seen = 1; end
        end
        if (!seen) begin errors++; $display("FAIL lastwins_timeout got none exp pulse"); end
        tick();
        checks++; if (cat_out !== 7'h24) begin errors++; $display("FAIL lastwins_digit0 got %h exp 24", cat_out); end
        repeat (N*CP) begin
            tick();
            if (commit_out) commits++;
        end
        checks++; if (commits !== 1) begin errors++; $display("FAIL lastwins_count got %0d exp 1", commits); end
    endtask

    task automatic test_coincident();
        for (int i = 0; i < N*CP && !at_boundary(); i++) tick();
        val_in = 32'h5; val_valid_in = 1;
        tick();
        checks++; if (commit_out !== 1'b1) begin errors++; $display("FAIL coincident_commit got %b exp 1", commit_out); end
        tick();
        checks++; if (cat_out !== 7'h12) begin errors++; $display("FAIL coincident_digit0 got %h exp 12", cat_out); end
        checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
            errors++; $display("FAIL coincident got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
    endtask

    task automatic test_lz();
        logic [31:0] vals[2];
        logic [7:0]  masks[2];
        vals[0] = 32'h42; vals[1] = 32'h0;
        masks[0] = 8'h03; masks[1] = 8'h01;
        lz_en_in = 1;
        for (int k = 0; k < 2; k++) begin
            logic seen = 0;
            logic [7:0] lowmask = 0;
            val_in = vals[k]; val_valid_in = 1;
            for (int i = 0; i < 2*N*CP && !seen; i++) begin
                tick();
                checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                    errors++; $display("FAIL lz_wait got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
                if (commit_out) seen = 1;
            end
            if (!seen) begin errors++; $display("FAIL lz_timeout got none exp pulse"); end
            repeat (N*CP) begin
                dp_in = 8'($urandom);
                tick();
                checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                    errors++; $display("FAIL lz_frame got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
                lowmask |= ~an_out;
            end
            checks++; if (lowmask !== masks[k]) begin errors++; $display("FAIL lz_mask val %h got %h exp %h", vals[k], lowmask, masks[k]); end
        end
        lz_en_in = 0;
    endtask

    task automatic test_enable();
        int dig;
        for (int i = 0; i < CP && (p % CP) != 1; i++) tick();
        dig = (p / CP) % N;
        en_in = 0;
        repeat (10) begin
            tick();
            checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL enable_dark got %h exp ff", an_out); end
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL enable_off got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
        end
        en_in = 1;
        tick();
        checks++; if (an_out !== ~(8'd1 << dig)) begin errors++; $display("FAIL enable_resume got %h exp %h", an_out, ~(8'd1 << dig)); end
        repeat (CP) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL enable_on got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            en_in = ($urandom % 8) != 0;
            lz_en_in = 1'($urandom);
            dp_in = 8'($urandom);
            val_valid_in = ($urandom % 12) == 0;
            val_in = $urandom >> ($urandom % 32);
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL random got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
        end
        en_in = 1; lz_en_in = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N*CP && (p % CP) != 2; i++) tick();
        val_in = 32'hDEAD_0001; val_valid_in = 1;
        tick();
        #2 rst_n_in = 0;
        #1;
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL areset_an got %h exp ff", an_out); end
        checks++; if (cat_out !== 7'h7F) begin errors++; $display("FAIL areset_cat got %h exp 7f", cat_out); end
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL areset_dp got %b exp 1", dp_out); end
        checks++; if (commit_out !== 1'b0) begin errors++; $display("FAIL areset_commit got %b exp 0", commit_out); end
        #2 rst_n_in = 1;
        model_reset();
        repeat (N*CP + 4) begin
            tick();
            checks++; if ({an_out, cat_out, dp_out, commit_out} !== {e_an, e_cat, e_dp, e_commit}) begin
                errors++; $display("FAIL areset_after got %h exp %h", {an_out, cat_out, dp_out, commit_out}, {e_an, e_cat, e_dp, e_commit}); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_last_wins();
        test_coincident();
        test_lz();
        test_enable();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
